// File: rtl/rgb565_to_ycbcr_if.sv
// Pixel-stream bundle for rgb565_to_ycbcr: raw RGB565 video in, YCbCr video out.
// master drives the input stream and observes the output; slave is the converter.
interface rgb565_to_ycbcr_if;
    logic        in_de;
    logic        in_hsync;
    logic        in_vsync;
    logic [15:0] in_rgb565;
    logic        out_de;
    logic        out_hsync;
    logic        out_vsync;
    logic [7:0]  y_out;
    logic [15:0] data_cbcr;
    logic        frame_start;

    modport master (
        output in_de, in_hsync, in_vsync, in_rgb565,
        input  out_de, out_hsync, out_vsync, y_out, data_cbcr, frame_start
    );

    modport slave (
        input  in_de, in_hsync, in_vsync, in_rgb565,
        output out_de, out_hsync, out_vsync, y_out, data_cbcr, frame_start
    );
endinterface

// File: rtl/rgb565_to_ycbcr.sv
// Three-stage RGB565 -> YCbCr (BT.601, 8-bit) converter with matched sync delay and frame_start flag.
// Define YCBCR_LIMITED_RANGE_EN to clamp Y to [16,235] and Cb/Cr to [16,240] in the last stage.
module rgb565_to_ycbcr #(
    parameter int ZERO_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst,
    rgb565_to_ycbcr_if.slave bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} fs_state_t;

    // Row-major coefficient table: Y (R,G,B), Cb (R,G,B), Cr (R,G,B) magnitudes.
    localparam logic [71:0] COEFS = {8'd77, 8'd150, 8'd29,
                                     8'd43, 8'd85,  8'd128,
                                     8'd128, 8'd107, 8'd21};

    logic [7:0]  r_r8, r_g8, r_b8;
    logic [2:0]  r_de_sr, r_hs_sr, r_vs_sr;
    logic [7:0]  w_s1_pix [3];
    logic [15:0] w_prod [9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r8    <= '0;
            r_g8    <= '0;
            r_b8    <= '0;
            r_de_sr <= '0;
            r_hs_sr <= '0;
            r_vs_sr <= '0;
        end else begin
            r_r8    <= {bus.in_rgb565[15:11], bus.in_rgb565[15:13]};
            r_g8    <= {bus.in_rgb565[10:5],  bus.in_rgb565[10:9]};
            r_b8    <= {bus.in_rgb565[4:0],   bus.in_rgb565[4:2]};
            r_de_sr <= {r_de_sr[1:0], bus.in_de};
            r_hs_sr <= {r_hs_sr[1:0], bus.in_hsync};
            r_vs_sr <= {r_vs_sr[1:0], bus.in_vsync};
        end
    end

    assign w_s1_pix[0] = r_r8;
    assign w_s1_pix[1] = r_g8;
    assign w_s1_pix[2] = r_b8;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_mul
            localparam int          SEL  = gi % 3;
            localparam logic [7:0]  COEF = COEFS[71 - 8*gi -: 8];
            logic [15:0] r_prod;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_prod <= '0;
                else     r_prod <= {8'd0, w_s1_pix[SEL]} * {8'd0, COEF};
            end
            assign w_prod[gi] = r_prod;
        end
    endgenerate

    function automatic logic signed [17:0] ext18(input logic [15:0] p);
        return $signed({2'b00, p});
    endfunction

    logic signed [17:0] w_y_sum, w_cb_sum, w_cr_sum;
    logic [7:0]         w_y8, w_cb8, w_cr8;
    logic [7:0]         w_y_c, w_cb_c, w_cr_c;

    always_comb begin
        w_y_sum  = ext18(w_prod[0]) + ext18(w_prod[1]) + ext18(w_prod[2]);
        w_cb_sum = ext18(w_prod[5]) - ext18(w_prod[3]) - ext18(w_prod[4]) + 18'sd32768;
        w_cr_sum = ext18(w_prod[6]) - ext18(w_prod[7]) - ext18(w_prod[8]) + 18'sd32768;
    end

    // Sums are provably within [0,65408], so truncating the shifted value is exact.
    assign w_y8  = 8'(w_y_sum  >>> 8);
    assign w_cb8 = 8'(w_cb_sum >>> 8);
    assign w_cr8 = 8'(w_cr_sum >>> 8);

`ifdef YCBCR_LIMITED_RANGE_EN
    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    assign w_y_c  = clamp8(w_y8,  8'd16, 8'd235);
    assign w_cb_c = clamp8(w_cb8, 8'd16, 8'd240);
    assign w_cr_c = clamp8(w_cr8, 8'd16, 8'd240);
`else
    assign w_y_c  = w_y8;
    assign w_cb_c = w_cb8;
    assign w_cr_c = w_cr8;
`endif

    logic w_blank;
    assign w_blank = (ZERO_BLANK != 0) && !r_de_sr[1];

    fs_state_t r_state, w_state_next;
    logic      w_fs_next, w_vs_edge;
    logic [7:0]  r_y;
    logic [15:0] r_cbcr;
    logic        r_fs;

    // Edge and pixel are judged on the values about to appear at the outputs,
    // so the registered pulse lands on the same cycle as its pixel.
    assign w_vs_edge = r_vs_sr[1] && !r_vs_sr[2];

    always_comb begin
        w_state_next = r_state;
        w_fs_next    = 1'b0;
        if (w_vs_edge) begin
            w_state_next = ST_ARMED;
        end else if (r_state == ST_ARMED && r_de_sr[1]) begin
            w_state_next = ST_IDLE;
            w_fs_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= '0;
            r_cbcr <= '0;
            r_fs   <= 1'b0;
        end else begin
            r_y    <= w_blank ? 8'd0  : w_y_c;
            r_cbcr <= w_blank ? 16'd0 : {w_cb_c, w_cr_c};
            r_fs   <= w_fs_next;
        end
    end

    assign bus.out_de      = r_de_sr[2];
    assign bus.out_hsync   = r_hs_sr[2];
    assign bus.out_vsync   = r_vs_sr[2];
    assign bus.y_out       = r_y;
    assign bus.data_cbcr   = r_cbcr;
    assign bus.frame_start = r_fs;
endmodule
